// File: rtl/mac_lut_table.sv
// MAC lookup table: register-side read/write req/ack responder plus a
// single-cycle, fully pipelined destination-MAC lookup port.
module mac_lut_table #(
  parameter int unsigned NUM_OUTPUT_QUEUES = 5,
  parameter int unsigned LUT_DEPTH_BITS    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LUT_DEPTH_BITS-1:0]    rd_addr,
  input  logic                         rd_req,
  output logic [NUM_OUTPUT_QUEUES-1:0] rd_oq,
  output logic                         rd_wr_protect,
  output logic [47:0]                  rd_mac,
  output logic                         rd_ack,
  input  logic [LUT_DEPTH_BITS-1:0]    wr_addr,
  input  logic                         wr_req,
  input  logic [NUM_OUTPUT_QUEUES-1:0] wr_oq,
  input  logic                         wr_protect,
  input  logic [47:0]                  wr_mac,
  output logic                         wr_ack,
  input  logic                         lookup_req,
  input  logic [47:0]                  lookup_mac,
  output logic                         lookup_done,
  output logic                         lookup_hit,
  output logic [NUM_OUTPUT_QUEUES-1:0] lookup_oq,
  output logic                         lut_hit,
  output logic                         lut_miss
);

  localparam int unsigned LutDepth = 2 ** LUT_DEPTH_BITS;

  typedef enum logic [1:0] {StIdle, StWrAck, StRdAck} state_e;

  state_e                       state_q, state_d;
  logic [47:0]                  mac_q   [LutDepth];
  logic [47:0]                  mac_d   [LutDepth];
  logic [NUM_OUTPUT_QUEUES-1:0] oq_q    [LutDepth];
  logic [NUM_OUTPUT_QUEUES-1:0] oq_d    [LutDepth];
  logic [LutDepth-1:0]          prot_q, prot_d;
  logic [LutDepth-1:0]          valid_q, valid_d;

  logic [NUM_OUTPUT_QUEUES-1:0] rd_oq_q, rd_oq_d;
  logic                         rd_wr_protect_q, rd_wr_protect_d;
  logic [47:0]                  rd_mac_q, rd_mac_d;
  logic                         rd_ack_q, rd_ack_d;
  logic                         wr_ack_q, wr_ack_d;

  logic                         lookup_done_q, lookup_done_d;
  logic                         lookup_hit_q, lookup_hit_d;
  logic [NUM_OUTPUT_QUEUES-1:0] lookup_oq_q, lookup_oq_d;
  logic                         lut_hit_q, lut_hit_d;
  logic                         lut_miss_q, lut_miss_d;

  logic                         match_hit;
  logic [NUM_OUTPUT_QUEUES-1:0] match_oq;

  always_comb begin
    state_d         = state_q;
    mac_d           = mac_q;
    oq_d            = oq_q;
    prot_d          = prot_q;
    valid_d         = valid_q;
    rd_oq_d         = rd_oq_q;
    rd_wr_protect_d = rd_wr_protect_q;
    rd_mac_d        = rd_mac_q;
    rd_ack_d        = rd_ack_q;
    wr_ack_d        = wr_ack_q;

    unique case (state_q)
      StIdle: begin
        if (wr_req) begin
          mac_d[wr_addr]   = wr_mac;
          oq_d[wr_addr]    = wr_oq;
          prot_d[wr_addr]  = wr_protect;
          valid_d[wr_addr] = |wr_oq;
          wr_ack_d         = 1'b1;
          state_d          = StWrAck;
        end else if (rd_req) begin
          rd_mac_d        = mac_q[rd_addr];
          rd_oq_d         = oq_q[rd_addr];
          rd_wr_protect_d = prot_q[rd_addr];
          rd_ack_d        = 1'b1;
          state_d         = StRdAck;
        end
      end
      StWrAck: begin
        if (!wr_req) begin
          wr_ack_d = 1'b0;
          state_d  = StIdle;
        end
      end
      StRdAck: begin
        if (!rd_req) begin
          rd_ack_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: begin
        wr_ack_d = 1'b0;
        rd_ack_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  // Scan from the top index down so the lowest matching index is the last to win.
  always_comb begin
    match_hit = 1'b0;
    match_oq  = '0;
    for (int i = LutDepth - 1; i >= 0; i--) begin
      if (valid_q[i] && (mac_q[i] == lookup_mac)) begin
        match_hit = 1'b1;
        match_oq  = oq_q[i];
      end
    end
    lookup_done_d = lookup_req;
    lookup_hit_d  = lookup_req & match_hit;
    lookup_oq_d   = lookup_req ? match_oq : '0;
    lut_hit_d     = lookup_req & match_hit;
    lut_miss_d    = lookup_req & ~match_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      for (int i = 0; i < LutDepth; i++) begin
        mac_q[i] <= '0;
        oq_q[i]  <= '0;
      end
      prot_q          <= '0;
      valid_q         <= '0;
      rd_oq_q         <= '0;
      rd_wr_protect_q <= 1'b0;
      rd_mac_q        <= '0;
      rd_ack_q        <= 1'b0;
      wr_ack_q        <= 1'b0;
      lookup_done_q   <= 1'b0;
      lookup_hit_q    <= 1'b0;
      lookup_oq_q     <= '0;
      lut_hit_q       <= 1'b0;
      lut_miss_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      mac_q           <= mac_d;
      oq_q            <= oq_d;
      prot_q          <= prot_d;
      valid_q         <= valid_d;
      rd_oq_q         <= rd_oq_d;
      rd_wr_protect_q <= rd_wr_protect_d;
      rd_mac_q        <= rd_mac_d;
      rd_ack_q        <= rd_ack_d;
      wr_ack_q        <= wr_ack_d;
      lookup_done_q   <= lookup_done_d;
      lookup_hit_q    <= lookup_hit_d;
      lookup_oq_q     <= lookup_oq_d;
      lut_hit_q       <= lut_hit_d;
      lut_miss_q      <= lut_miss_d;
    end
  end

  assign rd_oq         = rd_oq_q;
  assign rd_wr_protect = rd_wr_protect_q;
  assign rd_mac        = rd_mac_q;
  assign rd_ack        = rd_ack_q;
  assign wr_ack        = wr_ack_q;
  assign lookup_done   = lookup_done_q;
  assign lookup_hit    = lookup_hit_q;
  assign lookup_oq     = lookup_oq_q;
  assign lut_hit       = lut_hit_q;
  assign lut_miss      = lut_miss_q;

endmodule

// File: tb/tb_mac_lut_table.sv
// Directed bench for mac_lut_table: handshakes, lookup priority, write/lookup
// ordering and asynchronous reset mid-handshake.
module tb_mac_lut_table;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rd_addr;
  logic        rd_req;
  logic [4:0]  rd_oq;
  logic        rd_wr_protect;
  logic [47:0] rd_mac;
  logic        rd_ack;
  logic [3:0]  wr_addr;
  logic        wr_req;
  logic [4:0]  wr_oq;
  logic        wr_protect;
  logic [47:0] wr_mac;
  logic        wr_ack;
  logic        lookup_req;
  logic [47:0] lookup_mac;
  logic        lookup_done;
  logic        lookup_hit;
  logic [4:0]  lookup_oq;
  logic        lut_hit;
  logic        lut_miss;

  int checks = 0;
  int errors = 0;

  localparam logic [47:0] MacA = 48'h0011_2233_4455;
  localparam logic [47:0] MacB = 48'h0A0B_0C0D_0E0F;
  localparam logic [47:0] MacC = 48'hAABB_CCDD_EEFF;

  mac_lut_table #(.NUM_OUTPUT_QUEUES(5), .LUT_DEPTH_BITS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_addr       (rd_addr),
    .rd_req        (rd_req),
    .rd_oq         (rd_oq),
    .rd_wr_protect (rd_wr_protect),
    .rd_mac        (rd_mac),
    .rd_ack        (rd_ack),
    .wr_addr       (wr_addr),
    .wr_req        (wr_req),
    .wr_oq         (wr_oq),
    .wr_protect    (wr_protect),
    .wr_mac        (wr_mac),
    .wr_ack        (wr_ack),
    .lookup_req    (lookup_req),
    .lookup_mac    (lookup_mac),
    .lookup_done   (lookup_done),
    .lookup_hit    (lookup_hit),
    .lookup_oq     (lookup_oq),
    .lut_hit       (lut_hit),
    .lut_miss      (lut_miss)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lookup(input string tag, input logic hit, input logic [4:0] oq);
    chk({tag, "_done"}, {47'd0, lookup_done}, 48'd1);
    chk({tag, "_hit"},  {47'd0, lookup_hit},  {47'd0, hit});
    chk({tag, "_oq"},   {43'd0, lookup_oq},   {43'd0, oq});
    chk({tag, "_lhit"}, {47'd0, lut_hit},     {47'd0, hit});
    chk({tag, "_miss"}, {47'd0, lut_miss},    {47'd0, ~hit});
  endtask

  task automatic do_write(input string tag, input logic [3:0] a, input logic p,
                          input logic [4:0] oq, input logic [47:0] mac);
    wr_addr = a; wr_protect = p; wr_oq = oq; wr_mac = mac; wr_req = 1'b1;
    tick();
    chk({tag, "_ack1"}, {47'd0, wr_ack}, 48'd1);
    tick();
    chk({tag, "_ackheld"}, {47'd0, wr_ack}, 48'd1);
    wr_req = 1'b0;
    tick();
    chk({tag, "_ackfall"}, {47'd0, wr_ack}, 48'd0);
  endtask

  task automatic do_read(input string tag, input logic [3:0] a, input logic p,
                         input logic [4:0] oq, input logic [47:0] mac);
    rd_addr = a; rd_req = 1'b1;
    tick();
    chk({tag, "_ack1"}, {47'd0, rd_ack}, 48'd1);
    chk({tag, "_mac"},  rd_mac, mac);
    chk({tag, "_oq"},   {43'd0, rd_oq}, {43'd0, oq});
    chk({tag, "_prot"}, {47'd0, rd_wr_protect}, {47'd0, p});
    rd_req = 1'b0;
    tick();
    chk({tag, "_ackfall"}, {47'd0, rd_ack}, 48'd0);
    chk({tag, "_macheld"}, rd_mac, mac);
  endtask

  task automatic do_lookup(input string tag, input logic [47:0] mac, input logic hit,
                           input logic [4:0] oq);
    lookup_req = 1'b1; lookup_mac = mac;
    tick();
    chk_lookup(tag, hit, oq);
    lookup_req = 1'b0;
    tick();
    chk({tag, "_idle"}, {43'd0, lookup_done, lookup_hit, lut_hit, lut_miss, |lookup_oq}, 48'd0);
  endtask

  initial begin
    reset = 1'b1;
    rd_addr = '0; rd_req = 1'b0;
    wr_addr = '0; wr_req = 1'b0; wr_oq = '0; wr_protect = 1'b0; wr_mac = '0;
    lookup_req = 1'b0; lookup_mac = '0;
    tick();
    tick();
    chk("rst_outs", {37'd0, rd_ack, wr_ack, lookup_done, lookup_hit, lut_hit, lut_miss,
                     |rd_oq, rd_wr_protect, |lookup_oq, |rd_mac[47:46], |rd_mac[45:0]}, 48'd0);
    reset = 1'b0;
    tick();

    // Empty table: read returns zeros, lookup misses.
    do_read("rd3_empty", 4'd3, 1'b0, 5'd0, 48'd0);
    do_lookup("lk_empty", MacA, 1'b0, 5'd0);
    do_lookup("lk_zero", 48'd0, 1'b0, 5'd0);

    do_write("wr5", 4'd5, 1'b1, 5'b00100, MacA);
    do_read("rd5", 4'd5, 1'b1, 5'b00100, MacA);

    // Three back-to-back hits, then a miss on an adjacent MAC.
    lookup_req = 1'b1; lookup_mac = MacA;
    tick(); chk_lookup("b2b0", 1'b1, 5'b00100);
    tick(); chk_lookup("b2b1", 1'b1, 5'b00100);
    tick(); chk_lookup("b2b2", 1'b1, 5'b00100);
    lookup_mac = MacA + 48'd1;
    tick(); chk_lookup("b2b_miss", 1'b0, 5'd0);
    lookup_req = 1'b0;
    tick();
    chk("b2b_idle", {47'd0, lookup_done | lut_hit | lut_miss}, 48'd0);

    // Lowest index wins; invalidating it exposes the next match.
    do_write("wr7", 4'd7, 1'b0, 5'b10000, MacB);
    do_write("wr2", 4'd2, 1'b0, 5'b00001, MacB);
    do_lookup("lk_prio", MacB, 1'b1, 5'b00001);
    do_write("wr2_inv", 4'd2, 1'b0, 5'b00000, MacB);
    do_lookup("lk_prio2", MacB, 1'b1, 5'b10000);

    // Simultaneous rd/wr at addr 4 with lookups around the write accept.
    rd_addr = 4'd4; rd_req = 1'b1;
    wr_addr = 4'd4; wr_req = 1'b1; wr_oq = 5'b01010; wr_protect = 1'b1; wr_mac = MacC;
    lookup_req = 1'b1; lookup_mac = MacC;
    tick();
    chk("both_wrack", {47'd0, wr_ack}, 48'd1);
    chk("both_rdack0", {47'd0, rd_ack}, 48'd0);
    chk_lookup("lk_prewrite", 1'b0, 5'd0);
    tick();
    chk_lookup("lk_postwrite", 1'b1, 5'b01010);
    chk("both_rdack1", {47'd0, rd_ack}, 48'd0);
    lookup_req = 1'b0; wr_req = 1'b0;
    tick();
    chk("both_wrfall", {47'd0, wr_ack}, 48'd0);
    chk("both_rdack2", {47'd0, rd_ack}, 48'd0);
    tick();
    chk("both_rdack", {47'd0, rd_ack}, 48'd1);
    chk("both_rdmac", rd_mac, MacC);
    chk("both_rdoq", {43'd0, rd_oq}, {43'd0, 5'b01010});
    chk("both_rdprot", {47'd0, rd_wr_protect}, 48'd1);
    rd_req = 1'b0;
    tick();
    chk("both_rdfall", {47'd0, rd_ack}, 48'd0);

    // Asynchronous reset while wr_ack is high.
    wr_addr = 4'd9; wr_oq = 5'b00010; wr_protect = 1'b0; wr_mac = MacA; wr_req = 1'b1;
    tick();
    chk("rstmid_ack", {47'd0, wr_ack}, 48'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_ackdrop", {47'd0, wr_ack}, 48'd0);
    chk("rstmid_rdmac", rd_mac, 48'd0);
    wr_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    do_lookup("lk_cleared", MacA, 1'b0, 5'd0);
    do_read("rd5_cleared", 4'd5, 1'b0, 5'd0, 48'd0);
    do_write("wr_after", 4'd15, 1'b1, 5'b11111, MacB);
    do_read("rd15", 4'd15, 1'b1, 5'b11111, MacB);
    do_lookup("lk_after", MacB, 1'b1, 5'b11111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_lut_table.md
Name: mac_lut_table

Overview:
- Responder side of the MAC LUT read/write handshake driven by the switch output-port-lookup register block.
- Holds the MAC table of {wr_protect, oq, mac, valid} entries in flops.
- Serves register-side read and write requests with a req/ack handshake.
- Serves a datapath destination-MAC lookup port with fixed latency, producing hit/miss pulses for the register block's counters.

Parameters:
NUM_OUTPUT_QUEUES, 5, width of the output-queue bitmap per entry
LUT_DEPTH_BITS, 4, table index width; LUT_DEPTH = 2**LUT_DEPTH_BITS entries (derived, not overridable)

Ports:
clk  in  1  sole clock
reset  in  1  asynchronous, active-high reset
rd_addr  in  LUT_DEPTH_BITS  entry index to read
rd_req  in  1  read request; held until rd_ack seen
rd_oq  out  NUM_OUTPUT_QUEUES  oq field of entry read
rd_wr_protect  out  1  wr_protect bit of entry read
rd_mac  out  48  MAC field of entry read
rd_ack  out  1  read data valid; held high until rd_req low
wr_addr  in  LUT_DEPTH_BITS  entry index to write
wr_req  in  1  write request; held until wr_ack seen
wr_oq  in  NUM_OUTPUT_QUEUES  oq field to write
wr_protect  in  1  wr_protect bit to write
wr_mac  in  48  MAC to write
wr_ack  out  1  write committed; held high until wr_req low
lookup_req  in  1  one-cycle lookup strobe, may assert every cycle
lookup_mac  in  48  destination MAC to match
lookup_done  out  1  one-cycle result strobe
lookup_hit  out  1  result matched a valid entry
lookup_oq  out  NUM_OUTPUT_QUEUES  oq of matching entry, 0 on miss
lut_hit  out  1  one-cycle pulse per hit
lut_miss  out  1  one-cycle pulse per miss

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0.
  - Every entry's mac, oq, wr_protect and valid go to 0.
  - Handshake FSM goes to IDLE.
  - Reset asserted mid-handshake drops the ack immediately. The requester must re-issue.
- Entry valid rule:
  - valid is set by a write with wr_oq != 0.
  - valid is cleared by a write with wr_oq == 0.
  - Only valid entries match.
- Handshake FSM states: IDLE, WR_ACK, RD_ACK.
- IDLE, wr_req=1:
  - At this edge the entry at wr_addr takes {wr_protect, wr_oq, wr_mac, valid}.
  - Go to WR_ACK; wr_ack=1 from the next cycle.
  - wr_req has priority when rd_req and wr_req are both high.
- IDLE, rd_req=1 and wr_req=0:
  - At this edge, register the entry at rd_addr onto rd_oq, rd_wr_protect and rd_mac.
  - Go to RD_ACK; rd_ack=1 from the next cycle.
- Handshake latency: request seen in cycle N, ack high in cycle N+1.
- WR_ACK: stay while wr_req=1; when wr_req=0, return to IDLE and clear wr_ack next cycle.
- RD_ACK: same, using rd_req/rd_ack.
- rd_* data is held stable from capture until the next read capture. It is not cleared when rd_ack falls.
- Requests are not re-accepted in the cycle the FSM returns to IDLE. The earliest new request is accepted one cycle after the ack falls.
- Lookup pipeline (1-cycle latency, fully pipelined):
  - lookup_req in cycle N: compare lookup_mac against all valid entries combinationally.
  - Registered results in cycle N+1: lookup_done=1; lookup_hit; lookup_oq; exactly one of lut_hit/lut_miss =1.
  - Multiple matches: the lowest index wins.
  - lookup_req=0: all lookup outputs are 0 next cycle.
- Simultaneous write and lookup in the same cycle: the lookup compares against pre-write contents. The new entry is visible to lookups from the following cycle.
- A read captured in the same cycle as a lookup is independent; both complete.
- The wr_protect bit is stored and returned only. No enforcement in this block.
- Index arithmetic is unsigned and full-width; every address value is a legal entry, with no out-of-range case.

Test Plan:
- Reset, then read addr 3 -> rd_ack high 1 cycle after rd_req; rd_mac=0, rd_oq=0, rd_wr_protect=0; lookup of any MAC -> lookup_hit=0, lut_miss pulse.
- Write addr 5 {protect=1, oq=5'b00100, mac=48'h0011_2233_4455}, then read addr 5 -> wr_ack 1 cycle after wr_req and held until wr_req drops; read returns the same fields.
- Lookup 48'h0011_2233_4455 in 3 back-to-back cycles -> 3 consecutive lookup_done with hit=1, oq=5'b00100, 3 lut_hit pulses; lookup 48'h0011_2233_4456 -> miss, oq=0.
- Same MAC written at addr 2 (oq=5'b00001) and addr 7 (oq=5'b10000) -> lookup returns oq=5'b00001. Rewrite addr 2 with oq=0 -> lookup returns 5'b10000.
- rd_req and wr_req asserted together at addr 4 -> write acked first, read acked after the wr_ack handshake and returns the new data. A lookup in the write's accept cycle misses; a lookup the next cycle hits.
- Assert reset while wr_ack is high -> wr_ack=0 immediately, table cleared, FSM in IDLE after reset release. A new write is accepted normally.
